// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler for the dual-write-port register file: round-robin grant of up to
// two producers per cycle, same-address conflict guard, registered write-port outputs.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      stall,
   output logic [1:0]                wr_en,
   output logic [ADDR_W-1:0]         wr_addr_0,
   output logic [ADDR_W-1:0]         wr_addr_1,
   output logic [DATA_W-1:0]         wr_data_0,
   output logic [DATA_W-1:0]         wr_data_1,
   output logic [2**ADDR_W-1:0]      pending_mask
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NREG  = 2**ADDR_W;

   logic [PTR_W-1:0]   rr_ptr_r;
   logic [PTR_W-1:0]   rr_nxt_s;
   logic [PTR_W-1:0]   idx0_s;
   logic [PTR_W-1:0]   idx1_s;
   logic               g0_s;
   logic               g1_s;
   logic [NUM_REQ-1:0] ready_s;
   logic [ADDR_W-1:0]  addr0_s;
   logic [ADDR_W-1:0]  addr1_s;
   logic [DATA_W-1:0]  data0_s;
   logic [DATA_W-1:0]  data1_s;
   logic [NREG-1:0]    mask_nxt_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (int'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // Round-robin scan from rr_ptr; port 1 skips requesters aliasing the port-0 address
   always_comb begin
      logic [PTR_W-1:0] p;
      int               idx;
      g0_s    = 1'b0;
      g1_s    = 1'b0;
      idx0_s  = '0;
      idx1_s  = '0;
      addr0_s = '0;
      addr1_s = '0;
      data0_s = '0;
      data1_s = '0;
      ready_s = '0;
      p       = '0;
      idx     = 0;
      if (!rst && !stall) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_r) + k;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            p   = PTR_W'(idx);
            if (req_valid[p] && !g0_s) begin
               g0_s       = 1'b1;
               idx0_s     = p;
               addr0_s    = req_addr[p*ADDR_W +: ADDR_W];
               data0_s    = req_data[p*DATA_W +: DATA_W];
               ready_s[p] = 1'b1;
            end else if (req_valid[p] && !g1_s && (req_addr[p*ADDR_W +: ADDR_W] != addr0_s)) begin
               g1_s       = 1'b1;
               idx1_s     = p;
               addr1_s    = req_addr[p*ADDR_W +: ADDR_W];
               data1_s    = req_data[p*DATA_W +: DATA_W];
               ready_s[p] = 1'b1;
            end else begin
               ready_s[p] = ready_s[p];
            end
         end
      end else begin
         ready_s = '0;
      end

      if (g1_s) begin
         rr_nxt_s = ptr_inc(idx1_s);
      end else if (g0_s) begin
         rr_nxt_s = ptr_inc(idx0_s);
      end else begin
         rr_nxt_s = rr_ptr_r;
      end

      for (int j = 0; j < NREG; j++) begin
         mask_nxt_s[j] = (g0_s && (addr0_s == ADDR_W'(j))) || (g1_s && (addr1_s == ADDR_W'(j)));
      end
   end

   assign req_ready = ready_s;

   // Output stage and round-robin pointer; an idle port keeps its last address/data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en        <= 2'b00;
         wr_addr_0    <= '0;
         wr_addr_1    <= '0;
         wr_data_0    <= '0;
         wr_data_1    <= '0;
         pending_mask <= '0;
         rr_ptr_r     <= '0;
      end else begin
         wr_en        <= {g1_s, g0_s};
         pending_mask <= mask_nxt_s;
         rr_ptr_r     <= rr_nxt_s;
         if (g0_s) begin
            wr_addr_0 <= addr0_s;
            wr_data_0 <= data0_s;
         end
         if (g1_s) begin
            wr_addr_1 <= addr1_s;
            wr_data_1 <= data1_s;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file on the write ports.
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 3;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            stall;
   logic [1:0]      wr_en;
   logic [AW-1:0]   wr_addr_0;
   logic [AW-1:0]   wr_addr_1;
   logic [DW-1:0]   wr_data_0;
   logic [DW-1:0]   wr_data_1;
   logic [7:0]      pending_mask;
   logic [DW-1:0]   rf [0:7];

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .stall(stall), .wr_en(wr_en), .wr_addr_0(wr_addr_0),
      .wr_addr_1(wr_addr_1), .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
      .pending_mask(pending_mask)
   );

   always #5 clk = ~clk;

   // register file being fed by the write ports
   always @(posedge clk) begin
      if (wr_en[0]) rf[wr_addr_0] <= wr_data_0;
      if (wr_en[1]) rf[wr_addr_1] <= wr_data_1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]         = v;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic clear_reqs;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
   endtask

   function automatic logic [DW-1:0] e2e_val(input int r);
      return 16'(32'hE000 + r * 32'h0111);
   endfunction

   task automatic test_reset;
      set_req(0, 1'b1, 3'd2, 16'hAAAA);
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready got %b want 000", req_ready); end
      checks++; if (wr_en !== 2'b00) begin errors++; $display("FAIL rst_wr_en got %b want 00", wr_en); end
      checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL rst_mask got %h want 00", pending_mask); end
      rst = 1'b0;
      set_req(1, 1'b1, 3'd5, 16'h5555);
      tick;
      checks++; if (wr_en !== 2'b11) begin errors++; $display("FAIL pre_rst_wr_en got %b want 11", wr_en); end
      rst = 1'b1;
      #1;
      checks++; if (wr_en !== 2'b00) begin errors++; $display("FAIL async_rst_wr_en got %b want 00", wr_en); end
      checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL async_rst_mask got %h want 00", pending_mask); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL async_rst_ready got %b want 000", req_ready); end
      tick;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL held_rst_ready got %b want 000", req_ready); end
      clear_reqs;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_two_diff;
      set_req(0, 1'b1, 3'd2, 16'hAAAA);
      set_req(1, 1'b1, 3'd5, 16'h5555);
      #1;
      checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL two_ready got %b want 011", req_ready); end
      tick;
      clear_reqs;
      checks++; if (wr_en !== 2'b11) begin errors++; $display("FAIL two_wr_en got %b want 11", wr_en); end
      checks++; if (wr_addr_0 !== 3'd2 || wr_addr_1 !== 3'd5) begin errors++; $display("FAIL two_addr got %0d/%0d want 2/5", wr_addr_0, wr_addr_1); end
      checks++; if (wr_data_0 !== 16'hAAAA || wr_data_1 !== 16'h5555) begin errors++; $display("FAIL two_data got %h/%h want aaaa/5555", wr_data_0, wr_data_1); end
      checks++; if (pending_mask !== 8'h24) begin errors++; $display("FAIL two_mask got %h want 24", pending_mask); end
      tick;
      checks++; if (wr_en !== 2'b00 || wr_data_0 !== 16'hAAAA) begin errors++; $display("FAIL idle_hold got %b/%h want 00/aaaa", wr_en, wr_data_0); end
      checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL idle_mask got %h want 00", pending_mask); end
   endtask

   task automatic test_conflict;
      set_req(0, 1'b1, 3'd3, 16'h0001);
      set_req(1, 1'b1, 3'd3, 16'h0002);
      #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL conf_ready1 got %b want 001", req_ready); end
      tick;
      set_req(0, 1'b0, 3'd0, 16'h0000);
      checks++; if (wr_en !== 2'b01 || wr_data_0 !== 16'h0001) begin errors++; $display("FAIL conf_out1 got %b/%h want 01/0001", wr_en, wr_data_0); end
      #1;
      checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL conf_ready2 got %b want 010", req_ready); end
      tick;
      clear_reqs;
      checks++; if (wr_en !== 2'b01 || wr_addr_0 !== 3'd3 || wr_data_0 !== 16'h0002) begin errors++; $display("FAIL conf_out2 got %b/%0d/%h want 01/3/0002", wr_en, wr_addr_0, wr_data_0); end
      tick;
      checks++; if (rf[3] !== 16'h0002) begin errors++; $display("FAIL conf_r3 got %h want 0002", rf[3]); end
   endtask

   task automatic test_fairness;
      logic [2:0]    exp_rdy [3];
      logic [AW-1:0] exp_a0 [3];
      logic [AW-1:0] exp_a1 [3];
      int            cnt [N];
      exp_rdy = '{3'b011, 3'b101, 3'b110};
      exp_a0  = '{3'd1, 3'd3, 3'd2};
      exp_a1  = '{3'd2, 3'd1, 3'd3};
      cnt     = '{0, 0, 0};
      rst = 1'b1;
      #1;
      rst = 1'b0;
      set_req(0, 1'b1, 3'd1, 16'h0100);
      set_req(1, 1'b1, 3'd2, 16'h0200);
      set_req(2, 1'b1, 3'd3, 16'h0300);
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (req_ready !== exp_rdy[c % 3]) begin errors++; $display("FAIL fair_ready c%0d got %b want %b", c, req_ready, exp_rdy[c % 3]); end
         for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
         tick;
         checks++; if (wr_en !== 2'b11 || wr_addr_0 !== exp_a0[c % 3] || wr_addr_1 !== exp_a1[c % 3]) begin
            errors++; $display("FAIL fair_out c%0d got %b/%0d/%0d want 11/%0d/%0d", c, wr_en, wr_addr_0, wr_addr_1, exp_a0[c % 3], exp_a1[c % 3]);
         end
      end
      for (int i = 0; i < N; i++) begin
         checks++; if (cnt[i] != 4) begin errors++; $display("FAIL fair_count req%0d got %0d want 4", i, cnt[i]); end
      end
      clear_reqs;
   endtask

   task automatic test_stall;
      set_req(2, 1'b1, 3'd6, 16'h1234);
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready c%0d got %b want 000", c, req_ready); end
         tick;
         checks++; if (wr_en !== 2'b00) begin errors++; $display("FAIL stall_wr_en c%0d got %b want 00", c, wr_en); end
      end
      stall = 1'b0;
      #1;
      checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL unstall_ready got %b want 100", req_ready); end
      tick;
      clear_reqs;
      checks++; if (wr_en !== 2'b01 || wr_addr_0 !== 3'd6 || wr_data_0 !== 16'h1234) begin errors++; $display("FAIL unstall_out got %b/%0d/%h want 01/6/1234", wr_en, wr_addr_0, wr_data_0); end
   endtask

   task automatic test_single;
      set_req(1, 1'b1, 3'd7, 16'h0777);
      #1;
      checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b want 010", req_ready); end
      tick;
      clear_reqs;
      checks++; if (wr_en !== 2'b01 || wr_addr_0 !== 3'd7 || wr_data_0 !== 16'h0777) begin errors++; $display("FAIL single_out got %b/%0d/%h want 01/7/0777", wr_en, wr_addr_0, wr_data_0); end
   endtask

   task automatic test_same_addr;
      int ord [3];
      ord = '{2, 0, 1};
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd4, 16'(16'h0010 + i));
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (req_ready !== 3'(1 << ord[c])) begin errors++; $display("FAIL same_ready c%0d got %b want %b", c, req_ready, 3'(1 << ord[c])); end
         tick;
         set_req(ord[c], 1'b0, 3'd0, 16'h0000);
         checks++; if (wr_en !== 2'b01 || wr_data_0 !== 16'(16'h0010 + ord[c])) begin errors++; $display("FAIL same_out c%0d got %b/%h want 01/%h", c, wr_en, wr_data_0, 16'(16'h0010 + ord[c])); end
      end
      tick;
      checks++; if (rf[4] !== 16'h0011) begin errors++; $display("FAIL same_r4 got %h want 0011", rf[4]); end
   endtask

   task automatic test_end_to_end;
      int         nxt [N];
      int         wcnt [8];
      logic [2:0] rdy;
      nxt  = '{1, 2, 3};
      wcnt = '{0, 0, 0, 0, 0, 0, 0, 0};
      for (int cyc = 0; cyc < 40 && !(nxt[0] > 7 && nxt[1] > 7 && nxt[2] > 7); cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (nxt[i] <= 7) set_req(i, 1'b1, 3'(nxt[i]), e2e_val(nxt[i]));
            else set_req(i, 1'b0, 3'd0, 16'h0000);
         end
         #1;
         rdy = req_ready;
         tick;
         if (wr_en[0]) wcnt[wr_addr_0]++;
         if (wr_en[1]) wcnt[wr_addr_1]++;
         for (int i = 0; i < N; i++) if (rdy[i] && req_valid[i]) nxt[i] += 3;
      end
      clear_reqs;
      tick;
      if (wr_en[0]) wcnt[wr_addr_0]++;
      if (wr_en[1]) wcnt[wr_addr_1]++;
      checks++; if (!(nxt[0] > 7 && nxt[1] > 7 && nxt[2] > 7)) begin errors++; $display("FAIL e2e_timeout got %0d/%0d/%0d pending", nxt[0], nxt[1], nxt[2]); end
      for (int r = 1; r < 8; r++) begin
         checks++; if (rf[r] !== e2e_val(r)) begin errors++; $display("FAIL e2e_r%0d got %h want %h", r, rf[r], e2e_val(r)); end
         checks++; if (wcnt[r] != 1) begin errors++; $display("FAIL e2e_count r%0d got %0d want 1", r, wcnt[r]); end
      end
   endtask

   initial begin
      rst   = 1'b1;
      stall = 1'b0;
      clear_reqs;
      tick;
      tick;
      test_reset;
      test_two_diff;
      test_conflict;
      test_fairness;
      test_stall;
      test_single;
      test_same_addr;
      test_end_to_end;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
